// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared widths, x0 constant and writeback request type
// Imported by regfile_wb_arbiter and rr_arbiter.
package regfile_wb_pkg;

  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_ADDR_WIDTH = 5;

  localparam logic [WB_ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] rd;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - one-hot arbiter, round-robin by default
// Optional feature: WB_FIXED_PRIO_EN selects lowest-index-wins priority with no pointer.
module rr_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o
);

`ifdef WB_FIXED_PRIO_EN

  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  // Descending scan so the lowest requesting index is written last and wins.
  always_comb begin
    gnt_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o = '0;
        gnt_o[i] = 1'b1;
      end
    end
  end

`else

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  // Search starts one past the last winner and wraps, so every source waits at most NUM_REQ-1 grants.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = PW'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        ptr_d      = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PW'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter with pending-write scoreboard
// Optional feature: WB_FIXED_PRIO_EN (fixed priority inside rr_arbiter).
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rd_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic                          wr_en_o,
  output logic [ADDR_WIDTH-1:0]         wr_addr_o,
  output logic [DATA_WIDTH-1:0]         wr_data_o,
  input  logic                          rsv_valid_i,
  input  logic [ADDR_WIDTH-1:0]         rsv_rd_i,
  input  logic [ADDR_WIDTH-1:0]         chk_rs1_i,
  input  logic [ADDR_WIDTH-1:0]         chk_rs2_i,
  output logic                          rs1_busy_o,
  output logic                          rs2_busy_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(REG_ZERO);

  logic [NUM_REQ-1:0]    gnt;
  logic                  any_gnt;
  logic [ADDR_WIDTH-1:0] win_rd;
  logic [DATA_WIDTH-1:0] win_data;

  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DEPTH-1:0]      sb_q, sb_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_valid_i),
    .gnt_o (gnt)
  );

  // Grants are forced low while reset is asserted so no source sees a completed handshake.
  assign req_ready_o = gnt & {NUM_REQ{rst_n}};
  assign any_gnt     = |gnt;

  always_comb begin
    win_rd   = '0;
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        win_rd   = req_rd_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        win_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    wr_en_d   = any_gnt && (win_rd != X0);
    wr_addr_d = wr_en_d ? win_rd   : wr_addr_q;
    wr_data_d = wr_en_d ? win_data : wr_data_q;
  end

  // Clear applies first so a same-edge reservation of the retiring register wins.
  always_comb begin
    sb_d = sb_q;
    if (wr_en_q) begin
      sb_d[wr_addr_q] = 1'b0;
    end
    if (rsv_valid_i && (rsv_rd_i != X0)) begin
      sb_d[rsv_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      sb_q      <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      sb_q      <= sb_d;
    end
  end

  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign rs1_busy_o = (chk_rs1_i != X0) && sb_q[chk_rs1_i];
  assign rs2_busy_o = (chk_rs2_i != X0) && sb_q[chk_rs2_i];

endmodule
